rf_write_arbiter: RTL and testbench

Owns the single register-file write port and shares it between the pipeline write-back result (the write-back mux output) and the multi-cycle multiply/divide unit (MDU). The pipeline has priority. A one-entry holding register parks an MDU result that loses arbitration. A starvation counter forces a one-cycle write-back stall so the parked result is guaranteed to retire. The block sits between the write-back stage, the MDU and the register file.

---
 rtl/rf_write_arbiter_pkg.sv | 20 ++
 rtl/rf_write_arbiter_if.sv | 38 +++
 rtl/rf_write_arbiter_hold_reg.sv | 46 ++++
 rtl/rf_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rf_write_arbiter_pkg : shared widths, arbiter state encoding, r0   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package rf_write_arbiter_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

  localparam int unsigned REG_ZERO = 0;

endpackage
`default_nettype wire

// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rf_write_arbiter_if : write-back, MDU and register-file port bundle|
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface rf_write_arbiter_if
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W
) ();

  logic              wb_we;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              mdu_valid;
  logic [ADDR_W-1:0] mdu_rd;
  logic [DATA_W-1:0] mdu_data;
  logic              mdu_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              stall_req;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_rd;

  modport slave (
    input  wb_we, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
    output mdu_ready, rf_we, rf_waddr, rf_wdata, stall_req, pend_valid, pend_rd
  );

  modport master (
    output wb_we, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready, rf_we, rf_waddr, rf_wdata, stall_req, pend_valid, pend_rd
  );

endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter_hold_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rf_hold_reg : one-entry holding register for a parked MDU result   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module rf_hold_reg
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              load_i,
  input  wire logic              clear_i,
  input  wire logic [ADDR_W-1:0] rd_i,
  input  wire logic [DATA_W-1:0] data_i,
  output logic                   valid_o,
  output logic      [ADDR_W-1:0] rd_o,
  output logic      [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      rd_q    <= rd_i;
      data_q  <= data_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign rd_o    = rd_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rf_write_arbiter : shares the RF write port between write-back and |
// | the MDU, parking losing MDU results and forcing starvation stalls  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = RF_DATA_W,
  parameter int unsigned ADDR_W       = RF_ADDR_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  rf_write_arbiter_if.slave  bus
);

  localparam int unsigned          CNT_W   = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CNT_W-1:0]     AGE_MAX = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [ADDR_W-1:0]    R0      = ADDR_W'(REG_ZERO);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  age_q, age_d;
  logic              stall_q, stall_d;

  logic              w_port_busy;
  logic              w_accept;
  logic              w_mdu_nz;
  logic              w_hold_load;
  logic              w_hold_clear;
  logic              w_pend_valid;
  logic [ADDR_W-1:0] w_pend_rd;
  logic [DATA_W-1:0] w_pend_data;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  assign w_port_busy = bus.wb_we && (bus.wb_rd != R0);
  assign w_accept    = bus.mdu_valid && !w_pend_valid;
  assign w_mdu_nz    = (bus.mdu_rd != R0);

  rf_hold_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (w_hold_load),
    .clear_i (w_hold_clear),
    .rd_i    (bus.mdu_rd),
    .data_i  (bus.mdu_data),
    .valid_o (w_pend_valid),
    .rd_o    (w_pend_rd),
    .data_o  (w_pend_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      age_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    age_d        = age_q;
    w_hold_load  = 1'b0;
    w_hold_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Only a nonzero, non-superseded result that loses the port is parked.
        if (w_accept && w_mdu_nz && w_port_busy && (bus.mdu_rd != bus.wb_rd)) begin
          w_hold_load = 1'b1;
          age_d       = '0;
          state_d     = (STARVE_LIMIT == 1) ? ST_FORCE : ST_PEND;
        end
      end
      ST_PEND: begin
        if (!w_port_busy || (bus.wb_rd == w_pend_rd)) begin
          w_hold_clear = 1'b1;
          age_d        = '0;
          state_d      = ST_IDLE;
        end else begin
          age_d = age_q + CNT_W'(1);
          if (age_d == AGE_MAX) begin
            state_d = ST_FORCE;
          end
        end
      end
      ST_FORCE: begin
        w_hold_clear = 1'b1;
        age_d        = '0;
        state_d      = ST_IDLE;
      end
      default: begin
        w_hold_clear = 1'b1;
        age_d        = '0;
        state_d      = ST_IDLE;
      end
    endcase
    stall_d = (state_d == ST_FORCE);
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    // The held write-back inputs are stale during FORCE, so the parked entry wins.
    if (state_q == ST_FORCE) begin
      w_we    = 1'b1;
      w_waddr = w_pend_rd;
      w_wdata = w_pend_data;
    end else if (w_port_busy) begin
      w_we    = 1'b1;
      w_waddr = bus.wb_rd;
      w_wdata = bus.wb_data;
    end else if (state_q == ST_PEND) begin
      w_we    = 1'b1;
      w_waddr = w_pend_rd;
      w_wdata = w_pend_data;
    end else if (w_accept && w_mdu_nz) begin
      w_we    = 1'b1;
      w_waddr = bus.mdu_rd;
      w_wdata = bus.mdu_data;
    end
  end

  assign bus.rf_we      = w_we && rst_n;
  assign bus.rf_waddr   = w_waddr;
  assign bus.rf_wdata   = w_wdata;
  assign bus.mdu_ready  = !w_pend_valid;
  assign bus.stall_req  = stall_q;
  assign bus.pend_valid = w_pend_valid;
  assign bus.pend_rd    = w_pend_rd;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rf_write_arbiter : directed stimulus with queue scoreboard      |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_rf_write_arbiter;

  logic clk;
  logic rst_n;
  int   cyc;
  bit   done;
  int   errors;
  int   checks;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int         cyc;
    logic       stall;
    logic       pend;
    logic       ready;
    logic [4:0] prd;
  } st_t;

  wr_t wq[$];
  st_t sq[$];

  rf_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  rf_write_arbiter #(
    .DATA_W       (32),
    .ADDR_W       (5),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic we, input logic [4:0] rd, input logic [31:0] d,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bus.wb_we     = we;
    bus.wb_rd     = rd;
    bus.wb_data   = d;
    bus.mdu_valid = mv;
    bus.mdu_rd    = mrd;
    bus.mdu_data  = md;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic exp_w(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.cyc = cyc; e.addr = a; e.data = d;
    wq.push_back(e);
  endtask

  task automatic exp_s(input logic st, input logic pv, input logic rdy, input logic [4:0] prd);
    st_t e;
    e.cyc = cyc; e.stall = st; e.pend = pv; e.ready = rdy; e.prd = prd;
    sq.push_back(e);
  endtask

  // Stimulus: inputs change just after posedge, expectations tagged with that cycle.
  initial begin
    errors = 0;
    checks = 0;
    done   = 1'b0;
    rst_n  = 1'b0;
    idle();
    tick();
    exp_s(0, 0, 1, 5'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Free port: direct MDU write
    set_in(0, 5'd0, 32'h0, 1, 5'd7, 32'h1234); exp_w(5'd7, 32'h1234); exp_s(0, 0, 1, 5'd0);
    tick(); idle(); exp_s(0, 0, 1, 5'd0);
    tick();

    // Conflict then retire; MDU offer while pending must be refused
    set_in(1, 5'd3, 32'h33, 1, 5'd8, 32'hAA); exp_w(5'd3, 32'h33); exp_s(0, 0, 1, 5'd0);
    tick(); set_in(0, 5'd0, 32'h0, 1, 5'd11, 32'hCC); exp_w(5'd8, 32'hAA); exp_s(0, 1, 0, 5'd8);
    tick(); idle(); exp_s(0, 0, 1, 5'd0);
    tick();

    // Starvation with STARVE_LIMIT = 4
    set_in(1, 5'd1, 32'h101, 1, 5'd9, 32'h99); exp_w(5'd1, 32'h101);
    tick(); set_in(1, 5'd2, 32'h102, 0, 5'd0, 32'h0); exp_w(5'd2, 32'h102); exp_s(0, 1, 0, 5'd9);
    tick(); set_in(1, 5'd3, 32'h103, 0, 5'd0, 32'h0); exp_w(5'd3, 32'h103); exp_s(0, 1, 0, 5'd9);
    tick(); set_in(1, 5'd4, 32'h104, 0, 5'd0, 32'h0); exp_w(5'd4, 32'h104); exp_s(0, 1, 0, 5'd9);
    tick(); set_in(1, 5'd5, 32'h105, 0, 5'd0, 32'h0); exp_w(5'd9, 32'h99);   exp_s(1, 1, 0, 5'd9);
    tick(); exp_w(5'd5, 32'h105); exp_s(0, 0, 1, 5'd0);
    tick(); idle(); exp_s(0, 0, 1, 5'd0);
    tick();

    // Kill of a parked entry by a younger pipeline write
    set_in(1, 5'd1, 32'h11, 1, 5'd5, 32'h5A); exp_w(5'd1, 32'h11);
    tick(); set_in(1, 5'd5, 32'h55, 0, 5'd0, 32'h0); exp_w(5'd5, 32'h55); exp_s(0, 1, 0, 5'd5);
    tick(); idle(); exp_s(0, 0, 1, 5'd0);
    tick(); exp_s(0, 0, 1, 5'd0);
    tick();

    // Kill in IDLE: same destination in the same cycle
    set_in(1, 5'd6, 32'h66, 1, 5'd6, 32'h77); exp_w(5'd6, 32'h66);
    tick(); idle(); exp_s(0, 0, 1, 5'd0);
    tick();

    // r0 from both sources: nothing written, no state change
    set_in(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF); exp_s(0, 0, 1, 5'd0);
    tick(); idle(); exp_s(0, 0, 1, 5'd0);
    tick();

    // Reset while pending discards the parked result
    set_in(1, 5'd2, 32'h22, 1, 5'd10, 32'hBB); exp_w(5'd2, 32'h22);
    tick(); set_in(1, 5'd3, 32'h33, 0, 5'd0, 32'h0); exp_w(5'd3, 32'h33); exp_s(0, 1, 0, 5'd10);
    tick(); rst_n = 1'b0; set_in(1, 5'd4, 32'h44, 0, 5'd0, 32'h0); exp_s(0, 0, 1, 5'd0);
    tick(); rst_n = 1'b1; idle(); exp_s(0, 0, 1, 5'd0);
    tick(); exp_s(0, 0, 1, 5'd0);
    tick();
    tick();
    done = 1'b1;
  end

  // Monitor and scoreboard: all comparisons and counters live here.
  always @(negedge clk) begin
    wr_t w;
    st_t s;
    if (bus.rf_we) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected cyc=%0d actual addr=%0d data=%h, required no write",
                 cyc, bus.rf_waddr, bus.rf_wdata);
      end else begin
        w = wq.pop_front();
        if (w.cyc != cyc || w.addr != bus.rf_waddr || w.data != bus.rf_wdata) begin
          errors++;
          $display("FAIL write cyc=%0d actual addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                   cyc, bus.rf_waddr, bus.rf_wdata, w.cyc, w.addr, w.data);
        end
      end
    end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
      checks++;
      errors++;
      w = wq.pop_front();
      $display("FAIL write_missing cyc=%0d actual none, required addr=%0d data=%h",
               cyc, w.addr, w.data);
    end

    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      s = sq.pop_front();
      checks++;
      if (bus.stall_req !== s.stall || bus.pend_valid !== s.pend || bus.mdu_ready !== s.ready ||
          (s.pend && bus.pend_rd !== s.prd)) begin
        errors++;
        $display("FAIL status cyc=%0d actual stall=%b pend=%b ready=%b prd=%0d, required stall=%b pend=%b ready=%b prd=%0d",
                 cyc, bus.stall_req, bus.pend_valid, bus.mdu_ready, bus.pend_rd,
                 s.stall, s.pend, s.ready, s.prd);
      end
    end

    if (done || cyc > 1000) begin
      checks++;
      if (!done || wq.size() != 0 || sq.size() != 0) begin
        errors++;
        $display("FAIL drain actual done=%b writes_left=%0d status_left=%0d, required done=1 and 0 left",
                 done, wq.size(), sq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

endmodule
`default_nettype wire
